// File: rtl/hdelay_line.sv
// rtl/hdelay_line.sv - runtime-programmable N-cycle data/valid delay line with stall, flush and prime flag
module hdelay_line #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_DEPTH  = 16,
    parameter logic        HINIT      = 1'b0,
    localparam int unsigned DLY_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic                  hclk,
    input  logic                  hres,
    input  logic                  hen,
    input  logic                  hflush,
    input  logic [DLY_W-1:0]      hdly,
    input  logic [DATA_WIDTH-1:0] hin,
    input  logic                  hin_valid,
    output logic [DATA_WIDTH-1:0] hout,
    output logic                  hout_valid,
    output logic                  hprimed
);

    logic [DATA_WIDTH-1:0] data_q [MAX_DEPTH];
    logic [MAX_DEPTH-1:0]  valid_q;
    logic [DLY_W-1:0]      cnt_q, cnt_d;
    logic [DLY_W-1:0]      eff_dly;

    // Oversized requests clamp to the deepest stage rather than wrapping.
    assign eff_dly = (hdly > DLY_W'(MAX_DEPTH)) ? DLY_W'(MAX_DEPTH) : hdly;

    always_comb begin
        hout       = hin;
        hout_valid = hin_valid;
        for (int k = 0; k < int'(MAX_DEPTH); k++) begin
            if (eff_dly == DLY_W'(k + 1)) begin
                hout       = data_q[k];
                hout_valid = valid_q[k];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hflush) begin
            cnt_d = '0;
        end else if (hen && (cnt_q != DLY_W'(MAX_DEPTH))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign hprimed = (cnt_q >= eff_dly);

    // Every stage is explicitly reset so the array maps to flops, not shift-register primitives.
    always_ff @(posedge hclk) begin
        if (!hres) begin
            for (int k = 0; k < int'(MAX_DEPTH); k++) begin
                data_q[k] <= {DATA_WIDTH{HINIT}};
            end
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (hen) begin
                data_q[0] <= hin;
                for (int k = 1; k < int'(MAX_DEPTH); k++) begin
                    data_q[k] <= data_q[k-1];
                end
            end
            if (hflush) begin
                valid_q <= '0;
            end else if (hen) begin
                valid_q[0] <= hin_valid;
                for (int k = 1; k < int'(MAX_DEPTH); k++) begin
                    valid_q[k] <= valid_q[k-1];
                end
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hdelay_line.sv
// tb/tb_hdelay_line.sv - randomized and directed checks of hdelay_line against a history-log model
module tb_hdelay_line;

    localparam int DW  = 8;
    localparam int MD  = 16;
    localparam int DLW = 5;

    logic           hclk = 1'b0;
    logic           hres, hen, hflush, hin_valid;
    logic [DLW-1:0] hdly;
    logic [DW-1:0]  hin;
    logic [DW-1:0]  out0, out1;
    logic           v0, v1, p0, p1;

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    always #5 hclk = ~hclk;

    hdelay_line #(.DATA_WIDTH(DW), .MAX_DEPTH(MD), .HINIT(1'b0)) dut0 (
        .hclk(hclk), .hres(hres), .hen(hen), .hflush(hflush), .hdly(hdly),
        .hin(hin), .hin_valid(hin_valid), .hout(out0), .hout_valid(v0), .hprimed(p0)
    );

    hdelay_line #(.DATA_WIDTH(DW), .MAX_DEPTH(MD), .HINIT(1'b1)) dut1 (
        .hclk(hclk), .hres(hres), .hen(hen), .hflush(hflush), .hdly(hdly),
        .hin(hin), .hin_valid(hin_valid), .hout(out1), .hout_valid(v1), .hprimed(p1)
    );

    // Model: a time-ordered log of every accepted sample; a flush invalidates all
    // entries logged before it, reset replaces the log with MD initial entries.
    typedef struct {
        logic [DW-1:0] data;
        logic          valid;
        bit            init;
        int            idx;
    } entry_t;

    entry_t log_q[$];
    int next_idx   = 0;
    int flush_mark = 0;
    int adv        = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_out(input logic h, output logic [DW-1:0] d,
                                      output logic v, output logic p);
        int eff;
        entry_t e;
        eff = (int'(hdly) > MD) ? MD : int'(hdly);
        if (eff == 0) begin
            d = hin;
            v = hin_valid;
        end else begin
            e = log_q[log_q.size() - eff];
            d = e.init ? {DW{h}} : e.data;
            v = e.valid && (e.idx >= flush_mark);
        end
        p = (((adv > MD) ? MD : adv) >= eff);
    endfunction

    task automatic model_edge();
        entry_t e;
        if (!hres) begin
            log_q.delete();
            for (int i = 0; i < MD; i++) begin
                e.data = '0; e.valid = 1'b0; e.init = 1'b1; e.idx = -1;
                log_q.push_back(e);
            end
            adv = 0;
            flush_mark = next_idx;
        end else begin
            if (hen) begin
                e.data = hin; e.valid = hin_valid; e.init = 1'b0; e.idx = next_idx;
                next_idx++;
                log_q.push_back(e);
                if (log_q.size() > MD + 4) void'(log_q.pop_front());
            end
            if (hflush) begin
                flush_mark = next_idx;
                adv = 0;
            end else if (hen) begin
                adv++;
            end
        end
    endtask

    task automatic compare_all();
        logic [DW-1:0] d;
        logic v, p;
        model_out(1'b0, d, v, p);
        check("h0_data", 32'(out0), 32'(d));
        check("h0_valid", 32'(v0), 32'(v));
        check("h0_primed", 32'(p0), 32'(p));
        model_out(1'b1, d, v, p);
        check("h1_data", 32'(out1), 32'(d));
        check("h1_valid", 32'(v1), 32'(v));
        check("h1_primed", 32'(p1), 32'(p));
    endtask

    task automatic step(input logic r, input logic e, input logic f, input logic [DLW-1:0] d,
                        input logic [DW-1:0] x, input logic xv);
        hres = r; hen = e; hflush = f; hdly = d; hin = x; hin_valid = xv;
        #1;
        if (checking) compare_all();
        @(posedge hclk);
        model_edge();
        @(negedge hclk);
    endtask

    initial begin
        @(negedge hclk);
        // Reset then fixed delay of 3
        step(1'b0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
        checking = 1'b1;
        #1;
        check("rst_out_h0", 32'(out0), 32'h00);
        check("rst_out_h1", 32'(out1), 32'hFF);
        check("rst_valid", 32'(v0), 32'h0);
        check("rst_primed", 32'(p0), 32'h0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 5'd3, 8'(i), 1'b1);
            if (i == 3) begin
                check("fix3_first_data", 32'(out0), 32'h01);
                check("fix3_first_valid", 32'(v0), 32'h1);
                check("fix3_primed", 32'(p0), 32'h1);
            end
        end

        // Stall mid-stream at delay 4
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 5'd4, 8'(8'h10 + i), 1'b1);
            if (i == 7) begin
                step(1'b1, 1'b0, 1'b0, 5'd4, 8'hEE, 1'b1);
                step(1'b1, 1'b0, 1'b0, 5'd4, 8'hEF, 1'b0);
                check("stall_hold", 32'(out0), 32'h14);
            end
        end

        // Bypass, then clamp 31 -> 16
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
        hdly = 5'd0; hin = 8'hA5; hin_valid = 1'b1;
        #1;
        check("bypass_data", 32'(out0), 32'hA5);
        check("bypass_primed", 32'(p0), 32'h1);
        step(1'b1, 1'b1, 1'b0, 5'd31, 8'hA5, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 5'd31, 8'h00, 1'b0);
        #1;
        check("clamp_data", 32'(out0), 32'hA5);
        check("clamp_valid", 32'(v0), 32'h1);

        // Flush with simultaneous advance at delay 2
        step(1'b1, 1'b1, 1'b0, 5'd2, 8'h55, 1'b1);
        step(1'b1, 1'b1, 1'b0, 5'd2, 8'h66, 1'b1);
        step(1'b1, 1'b1, 1'b1, 5'd2, 8'h77, 1'b1);
        #1;
        check("flush_data", 32'(out0), 32'h66);
        check("flush_valid", 32'(v0), 32'h0);
        check("flush_primed", 32'(p0), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 5'd2, 8'(8'h80 + i), 1'b1);

        // Runtime delay growth after reset-only fill
        step(1'b0, 1'b1, 1'b0, 5'd2, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 5'd2, 8'(8'h30 + i), 1'b1);
        hdly = 5'd5;
        #1;
        check("grow_h1_data", 32'(out1), 32'hFF);
        check("grow_valid", 32'(v1), 32'h0);
        check("grow_primed", 32'(p1), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 5'd5, 8'(8'h40 + i), 1'b1);

        // Reset during flush and advance
        step(1'b0, 1'b1, 1'b1, 5'd3, 8'h99, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 5'd3, 8'(8'h50 + i), 1'b1);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0),
                 (($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                : 5'($urandom_range(0, 6))),
                 8'($urandom),
                 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdelay_line.md
Name: hdelay_line

Overview:
- Parametrised successor to the single-cycle delay register: a runtime-programmable N-cycle delay line carrying data plus a valid flag.
- Provides clock-enable stall, flush and a priming indicator.
- Used to align data paths of unequal pipeline latency in the LRF datapath.
- Delay is selected per cycle from 0 (bypass) to MAX_DEPTH stages.

Parameters:
- DATA_WIDTH, 8, width of the data payload per stage.
- MAX_DEPTH, 16, number of physical register stages (>=1).
- HINIT, 1'b0, bit value replicated across every data stage on reset.
- Derived (localparam, not overridable): DLY_W = $clog2(MAX_DEPTH+1).

Ports:
- hclk  in  1  clock, all state updates on rising edge.
- hres  in  1  synchronous active-low reset.
- hen  in  1  advance enable; 0 holds every stage and the counter.
- hflush  in  1  clears all valid flags and the prime counter.
- hdly  in  DLY_W  requested delay in advancing cycles; 0 = bypass.
- hin  in  DATA_WIDTH  input data.
- hin_valid  in  1  input valid.
- hout  out  DATA_WIDTH  delayed data.
- hout_valid  out  1  delayed valid.
- hprimed  out  1  high when at least eff_dly advances have occurred since the last reset or flush.

Behaviour:
- Reset, hres=0 at a rising edge:
  - All data stages become {DATA_WIDTH{HINIT}}, all valid flags 0, prime counter 0.
  - Reset overrides hen and hflush.
- Effective delay: eff_dly = min(hdly, MAX_DEPTH). Values above MAX_DEPTH are clamped, never wrapped.
- Stages S[0..MAX_DEPTH-1], each holding {data, valid}.
  - On a rising edge with hres=1 and hen=1: S[0] <= {hin, hin_valid}, and S[k] <= S[k-1] for k>=1.
  - With hen=0: all stages hold, regardless of hin/hin_valid.
- Output tap (combinational from the registers and hdly):
  - eff_dly>=1: hout = S[eff_dly-1].data, hout_valid = S[eff_dly-1].valid. Latency is exactly eff_dly advancing edges.
  - eff_dly=0: hout = hin, hout_valid = hin_valid. This is the only combinational path from input to output.
- hdly may change on any cycle. The tap moves immediately, with no draining or refilling.
  - Data already in the stages is retained. Growing the delay exposes older stage contents, including HINIT/invalid entries after reset or flush.
  - Downstream must qualify on hout_valid.
- Flush, hflush=1 with hres=1:
  - At the edge, all valid flags (including the one entering S[0]) become 0 and the prime counter becomes 0.
  - Data still shifts if hen=1, otherwise holds. Data is never cleared by flush.
- Prime counter:
  - Saturating, width DLY_W, saturates at MAX_DEPTH.
  - Increments on each edge with hen=1 and hflush=0.
  - hprimed = (count >= eff_dly). Hence hprimed=1 whenever eff_dly=0.
  - Lowering hdly may raise hprimed combinationally; raising hdly may drop it.
- Priority per edge: reset > flush > shift/hold.
- Output reset values: with hdly>=1, hout = {DATA_WIDTH{HINIT}}, hout_valid=0, hprimed=0. With hdly=0, the outputs follow the bypass rules.
- No X propagation: every stage is reset. Synthesis must infer flip-flops, not SRL/RAM, so that reset holds.

Test Plan:
- Reset then fixed delay: HINIT=0, MAX_DEPTH=16, hdly=3, hen=1, hin=0x01,0x02,... with valid=1 from cycle 0 -> hout_valid first high after the 3rd edge with hout=0x01, then sequential values; hprimed rises after the same 3rd edge.
- Stall: hdly=4, stream 0x10..0x1F, hen=0 for 2 cycles mid-stream -> hout/hout_valid frozen for those 2 cycles; sequence resumes with no loss or duplication; total latency = 4 advancing edges.
- Bypass and clamp: hdly=0, hin=0xA5 -> hout=0xA5 same cycle, hprimed=1. hdly=31 with MAX_DEPTH=16 -> behaves exactly as hdly=16 (0xA5 appears after 16 advancing edges).
- Flush with simultaneous advance: hdly=2, pipe full of valid 0x55/0x66, assert hflush with hen=1 and hin=0x77 valid -> next 2 cycles hout_valid=0 with data 0x66 then 0x77 visible; hprimed=0 until 2 further advances.
- Runtime delay change: hdly=2 steady stream, switch to hdly=5 -> tap immediately shows S[4] contents. After reset-only fill (HINIT=1, DATA_WIDTH=8) the tap shows 0xFF, valid=0, and hprimed drops until the count reaches 5.
- Reset mid-operation: hres=0 for one edge while streaming with hflush=1, hen=1 -> all stages HINIT/invalid, counter 0; the stream restarts cleanly with latency hdly.
